// File: rtl/exm_pkg.sv
// ============================================================================
// Module : exm_pkg
// Brief  : Shared defaults, payload layout and lane state for the EX/MEM group
//          synchroniser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exm_pkg;

    localparam int LANES_DEF = 2;
    localparam int RES_W_DEF = 72;
    localparam int CNT_W_DEF = 16;

    // Lane payload layout, LSB first; bit 71 is spare.
    localparam int PC_LSB     = 0;
    localparam int PC_W       = 32;
    localparam int RESULT_LSB = 32;
    localparam int RESULT_W   = 32;
    localparam int DEST_LSB   = 64;
    localparam int DEST_W     = 5;
    localparam int GR_WE_BIT  = 69;
    localparam int CSR_WE_BIT = 70;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } lane_state_t;

endpackage : exm_pkg

`default_nettype wire

// File: rtl/exm_lane_hold.sv
// ============================================================================
// Module : exm_lane_hold
// Brief  : Per-lane result hold; keeps the first result until the group fires.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exm_lane_hold
    import exm_pkg::*;
#(
    parameter int RES_W = RES_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             fire,
    input  logic             valid,
    input  logic             done,
    input  logic [RES_W-1:0] result,
    output logic             complete,
    output logic [RES_W-1:0] merged
);

    lane_state_t      r_state;
    logic [RES_W-1:0] r_hold;
    logic             w_held;

    assign w_held   = (r_state == HELD);
    assign complete = ~valid | w_held | done;
    assign merged   = w_held ? r_hold : result;

    // Late done pulses on a held lane are ignored so the first result wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_hold  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (valid && done && !fire && !flush) begin
                        r_state <= HELD;
                        r_hold  <= result;
                    end
                end
                HELD: begin
                    if (fire || flush) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule : exm_lane_hold

`default_nettype wire

// File: rtl/exm_group_sync.sv
// ============================================================================
// Module : exm_group_sync
// Brief  : N-lane completion synchroniser; releases a group to one WB slot
//          once every occupied lane has produced its result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exm_group_sync
    import exm_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int RES_W = RES_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES-1:0]       in_done,
    input  logic [LANES*RES_W-1:0] in_result,
    output logic                   in_ready,
    output logic [LANES-1:0]       lane_wait,
    output logic                   out_valid,
    output logic [LANES-1:0]       out_lane_valid,
    output logic [LANES*RES_W-1:0] out_result,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [LANES-1:0]       w_complete;
    logic [LANES*RES_W-1:0] w_merged;
    logic                   w_fire;
    logic                   w_stall;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        exm_lane_hold #(
            .RES_W (RES_W)
        ) u_hold (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .fire     (w_fire),
            .valid    (in_valid[g]),
            .done     (in_done[g]),
            .result   (in_result[g*RES_W +: RES_W]),
            .complete (w_complete[g]),
            .merged   (w_merged[g*RES_W +: RES_W])
        );
    end

    // The slot can reload in the same cycle WB drains it.
    assign w_fire    = (&w_complete) & (~out_valid | out_ready) & ~flush;
    assign in_ready  = w_fire;
    assign lane_wait = in_valid & ~w_complete;
    assign w_stall   = (|in_valid) & ~w_fire & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
            out_result     <= '0;
        end else if (w_fire) begin
            out_valid      <= |in_valid;
            out_lane_valid <= in_valid;
            out_result     <= w_merged;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (w_stall && (stall_cnt != c_CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule : exm_group_sync

`default_nettype wire
